wb_merge: RTL and testbench

- Write-back merge stage directly upstream of the register file; owns the file's single write port.
- Merges two write sources:
  - the in-order pipeline write-back, which has priority and never stalls;
  - a long-latency unit (mul/div, uncached load) with a valid/ready handshake, buffered in a DEPTH-entry FIFO.
- Drives registered reg_w/RdC/Rd_data_in, which the register file commits on the following negedge.
- Exports per-register busy flags so decode stalls on operands still queued.

---
 rtl/wb_merge_if.sv | 35 +++
 rtl/wb_merge.sv | 92 +++++++++
 tb/tb_wb_merge.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/wb_merge_if.sv
// Bus bundle between the write-back merge stage and its neighbours:
// pipeline write-back, long-latency handshake, register-file write port and decode busy checks.
interface wb_merge_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              p_valid;
   logic [ADDR_W-1:0] p_rd;
   logic [DATA_W-1:0] p_data;
   logic              l_valid;
   logic              l_ready;
   logic [ADDR_W-1:0] l_rd;
   logic [DATA_W-1:0] l_data;
   logic              reg_w;
   logic [ADDR_W-1:0] RdC;
   logic [DATA_W-1:0] Rd_data_in;
   logic [ADDR_W-1:0] chk_rs;
   logic [ADDR_W-1:0] chk_rt;
   logic              busy_rs;
   logic              busy_rt;
   logic [CW-1:0]     fifo_cnt;

   modport master (
      output p_valid, p_rd, p_data, l_valid, l_rd, l_data, chk_rs, chk_rt,
      input  l_ready, reg_w, RdC, Rd_data_in, busy_rs, busy_rt, fifo_cnt
   );

   modport slave (
      input  p_valid, p_rd, p_data, l_valid, l_rd, l_data, chk_rs, chk_rt,
      output l_ready, reg_w, RdC, Rd_data_in, busy_rs, busy_rt, fifo_cnt
   );
endinterface

// File: rtl/wb_merge.sv
// Write-back merge: the pipeline has priority on the register-file write port, and long-latency
// results wait in a small FIFO that drains on idle pipeline cycles. It also flags registers with pending writes.
module wb_merge #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic       reg_clk,
   input logic       rst,
   wb_merge_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [ADDR_W-1:0] q_rd   [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];
   logic [DEPTH-1:0]  q_valid;
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;
   logic              out_fifo;
   logic              pipe_sel;
   logic              pop;
   logic              push;
   logic              hit_rs;
   logic              hit_rt;

   assign pipe_sel     = bus.p_valid && (bus.p_rd != '0);
   assign pop          = !pipe_sel && (count != '0);
   assign bus.l_ready  = rst && (count < DEPTH_C);
   // A write to r0 completes the handshake but is never queued.
   assign push         = bus.l_valid && bus.l_ready && (bus.l_rd != '0);
   assign bus.fifo_cnt = count;

   always_ff @(posedge reg_clk) begin
      if (!rst) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         q_valid        <= '0;
         out_fifo       <= 1'b0;
         bus.reg_w      <= 1'b0;
         bus.RdC        <= '0;
         bus.Rd_data_in <= '0;
      end else begin
         if (push) begin
            q_rd[tail]    <= bus.l_rd;
            q_data[tail]  <= bus.l_data;
            q_valid[tail] <= 1'b1;
            tail          <= tail + 1'b1;
         end
         if (pop) begin
            q_valid[head] <= 1'b0;
            head          <= head + 1'b1;
         end
         count <= count + CW'(push) - CW'(pop);

         if (pipe_sel) begin
            bus.reg_w      <= 1'b1;
            bus.RdC        <= bus.p_rd;
            bus.Rd_data_in <= bus.p_data;
            out_fifo       <= 1'b0;
         end else if (pop) begin
            bus.reg_w      <= 1'b1;
            bus.RdC        <= q_rd[head];
            bus.Rd_data_in <= q_data[head];
            out_fifo       <= 1'b1;
         end else begin
            bus.reg_w      <= 1'b0;
            out_fifo       <= 1'b0;
         end
      end
   end

   // A popped entry still counts as pending until the register file has taken it.
   always_comb begin
      hit_rs = 1'b0;
      hit_rt = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (q_valid[i] && (q_rd[i] == bus.chk_rs)) hit_rs = 1'b1;
         if (q_valid[i] && (q_rd[i] == bus.chk_rt)) hit_rt = 1'b1;
      end
      if (bus.reg_w && out_fifo && (bus.RdC == bus.chk_rs)) hit_rs = 1'b1;
      if (bus.reg_w && out_fifo && (bus.RdC == bus.chk_rt)) hit_rt = 1'b1;
      if (bus.chk_rs == '0) hit_rs = 1'b0;
      if (bus.chk_rt == '0) hit_rt = 1'b0;
   end

   assign bus.busy_rs = hit_rs;
   assign bus.busy_rt = hit_rt;
endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge: pipeline priority, FIFO ordering/backpressure, busy flags and reset flush.
module tb_wb_merge;
   logic reg_clk = 1'b0;
   logic rst     = 1'b0;
   int   total   = 0;
   int   bad     = 0;

   wb_merge_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) bus ();

   wb_merge #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
      .reg_clk (reg_clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #5 reg_clk = ~reg_clk;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Advance one posedge and settle just past it so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge reg_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
      bus.p_valid = pv;
      bus.p_rd    = prd;
      bus.p_data  = pdat;
      bus.l_valid = lv;
      bus.l_rd    = lrd;
      bus.l_data  = ldat;
      #1;
   endtask

   initial begin
      bus.chk_rs = '0;
      bus.chk_rt = '0;
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      tick();
      checkOutput("rst_l_ready", 64'(bus.l_ready), 0);
      rst = 1'b1;
      #1;
      checkOutput("rel_l_ready", 64'(bus.l_ready), 1);
      checkOutput("rel_reg_w", 64'(bus.reg_w), 0);
      checkOutput("rel_RdC", 64'(bus.RdC), 0);
      checkOutput("rel_data", 64'(bus.Rd_data_in), 0);
      checkOutput("rel_cnt", 64'(bus.fifo_cnt), 0);

      // single pipeline write
      applyStimulus(1, 3, 32'h1234, 0, 0, 0);
      tick();
      checkOutput("p_reg_w", 64'(bus.reg_w), 1);
      checkOutput("p_RdC", 64'(bus.RdC), 3);
      checkOutput("p_data", 64'(bus.Rd_data_in), 64'h1234);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("p_idle_reg_w", 64'(bus.reg_w), 0);
      checkOutput("p_hold_RdC", 64'(bus.RdC), 3);

      // two long-latency writes queued behind a busy pipeline
      applyStimulus(1, 2, 32'h20, 1, 5, 32'hA);
      tick();
      applyStimulus(1, 4, 32'h40, 1, 6, 32'hB);
      tick();
      applyStimulus(1, 4, 32'h40, 0, 0, 0);
      bus.chk_rs = 5'd5;
      bus.chk_rt = 5'd6;
      #1;
      checkOutput("q2_cnt", 64'(bus.fifo_cnt), 2);
      checkOutput("q2_RdC", 64'(bus.RdC), 4);
      checkOutput("q2_busy_rs", 64'(bus.busy_rs), 1);
      checkOutput("q2_busy_rt", 64'(bus.busy_rt), 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("d1_RdC", 64'(bus.RdC), 5);
      checkOutput("d1_data", 64'(bus.Rd_data_in), 64'hA);
      checkOutput("d1_cnt", 64'(bus.fifo_cnt), 1);
      checkOutput("d1_busy_rs", 64'(bus.busy_rs), 1);
      tick();
      checkOutput("d2_RdC", 64'(bus.RdC), 6);
      checkOutput("d2_data", 64'(bus.Rd_data_in), 64'hB);
      checkOutput("d2_cnt", 64'(bus.fifo_cnt), 0);
      checkOutput("d2_busy_rs", 64'(bus.busy_rs), 0);
      checkOutput("d2_busy_rt", 64'(bus.busy_rt), 1);
      tick();
      checkOutput("d3_reg_w", 64'(bus.reg_w), 0);
      checkOutput("d3_busy_rt", 64'(bus.busy_rt), 0);

      // fill to DEPTH, fifth request must wait for a free slot
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1, 2, 32'h20, 1, 5'(8 + k), 32'(8'h80 + 8'(k * 16)));
         checkOutput("fill_l_ready", 64'(bus.l_ready), 1);
         tick();
      end
      applyStimulus(1, 2, 32'h20, 1, 12, 32'hC0);
      checkOutput("full_cnt", 64'(bus.fifo_cnt), 4);
      checkOutput("full_l_ready", 64'(bus.l_ready), 0);
      tick();
      checkOutput("full_hold_cnt", 64'(bus.fifo_cnt), 4);
      applyStimulus(0, 0, 0, 1, 12, 32'hC0);
      checkOutput("full_no_pass", 64'(bus.l_ready), 0);
      tick();
      checkOutput("f_pop8_RdC", 64'(bus.RdC), 8);
      checkOutput("f_pop8_data", 64'(bus.Rd_data_in), 64'h80);
      checkOutput("f_pop8_cnt", 64'(bus.fifo_cnt), 3);
      checkOutput("f_ready_again", 64'(bus.l_ready), 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("f_pop9_RdC", 64'(bus.RdC), 9);
      checkOutput("f_pushpop_cnt", 64'(bus.fifo_cnt), 3);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("f_drain_RdC", 64'(bus.RdC), 64'(10 + k));
         checkOutput("f_drain_data", 64'(bus.Rd_data_in), 64'(8'hA0 + 8'(k * 16)));
         checkOutput("f_drain_cnt", 64'(bus.fifo_cnt), 64'(2 - k));
      end

      // p_rd=0 counts as idle, and an r0 long-latency write is dropped
      applyStimulus(1, 2, 32'h20, 1, 7, 32'h77);
      tick();
      checkOutput("r0_q_cnt", 64'(bus.fifo_cnt), 1);
      applyStimulus(1, 0, 32'h99, 0, 0, 0);
      tick();
      checkOutput("r0_drain_RdC", 64'(bus.RdC), 7);
      checkOutput("r0_drain_data", 64'(bus.Rd_data_in), 64'h77);
      checkOutput("r0_drain_cnt", 64'(bus.fifo_cnt), 0);
      applyStimulus(0, 0, 0, 1, 0, 32'h55);
      checkOutput("l0_l_ready", 64'(bus.l_ready), 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("l0_cnt", 64'(bus.fifo_cnt), 0);
      checkOutput("l0_reg_w", 64'(bus.reg_w), 0);
      tick();
      checkOutput("l0_no_write", 64'(bus.reg_w), 0);

      // reset flushes queued writes
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 2, 32'h20, 1, 5'(13 + k), 32'(k));
         tick();
      end
      applyStimulus(1, 2, 32'h20, 0, 0, 0);
      bus.chk_rs = 5'd13;
      bus.chk_rt = 5'd15;
      #1;
      checkOutput("pre_rst_cnt", 64'(bus.fifo_cnt), 3);
      checkOutput("pre_rst_busy", 64'(bus.busy_rs), 1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      tick();
      checkOutput("flush_cnt", 64'(bus.fifo_cnt), 0);
      checkOutput("flush_busy_rs", 64'(bus.busy_rs), 0);
      checkOutput("flush_busy_rt", 64'(bus.busy_rt), 0);
      checkOutput("flush_reg_w", 64'(bus.reg_w), 0);
      checkOutput("flush_l_ready", 64'(bus.l_ready), 0);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("post_flush_reg_w", 64'(bus.reg_w), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
